// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The byte-lane word type places lane 0 in the most significant byte (big-endian).
package mem_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_bytes_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int READ_LATENCY_DEF  = 4;
  localparam int WRITE_LATENCY_DEF = 5;

  // Word index of a byte address; upper bits wrap modulo the memory size.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned mem_bytes);
    logic [31:0] mask_s;
    mask_s = 32'(mem_bytes) - 32'd1;
    return (addr & mask_s) >> 2;
  endfunction

endpackage

// File: rtl/data_memory_responder_bank.sv
// Single-port synchronous byte RAM used as one lane of the responder's word store.
// Contents are not reset; the read port returns the pre-write contents.
module byte_bank_ram
  import mem_pkg::*;
#(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  byte_t             wdata,
  output byte_t             rdata
);

  byte_t mem_r [DEPTH];

  // Storage write and registered read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency main-memory responder with a req/busy/done handshake.
// One request in flight; read data in big-endian lane order, held until the next read completes.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int MEM_BYTES     = 65536,
  parameter int READ_LATENCY  = READ_LATENCY_DEF,
  parameter int WRITE_LATENCY = WRITE_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] address_input,
  input  logic        write_en_in,
  input  word_bytes_t mem_data_in,
  output word_bytes_t mem_data_out,
  output logic        busy,
  output logic        done
);

  localparam int DEPTH = MEM_BYTES / 4;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  mem_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, load_s;
  logic [IDX_W-1:0]  idx_r, req_idx_s, ram_addr_s;
  logic              wr_r, ram_we_s;
  word_bytes_t       wdata_r;
  byte_t             bank_rdata_s [4];

  assign req_idx_s = IDX_W'(word_index(address_input, MEM_BYTES));
  assign load_s    = write_en_in ? WR_LOAD : RD_LOAD;

  // Next-state logic: a zero load means latency 1, which skips WAIT
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_nxt_s = (load_s == {CNT_W{1'b0}}) ? RESP : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // RAM port: in IDLE, look up the incoming address so that latency-1 reads have data ready
  always_comb begin
    ram_addr_s = idx_r;
    if (state_r == IDLE) begin
      ram_addr_s = req_idx_s;
    end else begin
      ram_addr_s = idx_r;
    end
    ram_we_s = (state_r == RESP) && wr_r && !reset;
  end

  // Request latch, latency counter and registered handshake/data outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      wr_r         <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      mem_data_out <= 32'h0000_0000;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            idx_r   <= req_idx_s;
            wr_r    <= write_en_in;
            wdata_r <= mem_data_in;
            cnt_r   <= load_s;
            busy    <= 1'b1;
          end
        end
        WAIT: cnt_r <= cnt_r - CNT_W'(1);
        RESP: begin
          if (!wr_r) begin
            mem_data_out <= {bank_rdata_s[0], bank_rdata_s[1], bank_rdata_s[2], bank_rdata_s[3]};
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  for (genvar lane = 0; lane < 4; lane++) begin : g_bank
    byte_bank_ram #(
      .DEPTH (DEPTH),
      .ADDR_W(IDX_W)
    ) u_bank (
      .clk  (clk),
      .we   (ram_we_s),
      .addr (ram_addr_s),
      .wdata(wdata_r[lane]),
      .rdata(bank_rdata_s[lane])
    );
  end

endmodule
